// File: rtl/peripheral_pkg.sv
// Shared definitions for the memory-mapped peripheral: register map,
// clock/baud defaults and the UART state encoding.
package peripheral_pkg;

   localparam int CLK_FREQ_DEFAULT = 50_000_000;
   localparam int BAUD_DEFAULT     = 9600;

   localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
   localparam logic [31:0] ADDR_TL       = 32'h4000_0004;
   localparam logic [31:0] ADDR_TCON     = 32'h4000_0008;
   localparam logic [31:0] ADDR_LED      = 32'h4000_000C;
   localparam logic [31:0] ADDR_SWITCH   = 32'h4000_0010;
   localparam logic [31:0] ADDR_DIGI     = 32'h4000_0014;
   localparam logic [31:0] ADDR_UART_TXD = 32'h4000_0018;
   localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
   localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/peripheral_uart_core.sv
// 8N1 UART transmitter and receiver with down-counting bit timers.
// state      | meaning
// UART_IDLE  | line idle (TX: waiting for tx_start, RX: waiting for falling edge)
// UART_START | start bit (TX: driving 0, RX: waiting for mid-start re-check)
// UART_DATA  | eight data bits, LSB first
// UART_STOP  | stop bit (TX: driving 1, RX: waiting for stop sample)
module peripheral_uart_core
   import peripheral_pkg::*;
#(
   parameter int BIT_CYCLES = 5208
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx_done_pulse,
   output logic       txd,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_done_pulse
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

   uart_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            txd_q, txd_d;
   logic            tx_tc;

   uart_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
   logic            rx_tc;

   assign tx_tc   = (tx_cnt_q == '0);
   assign rx_tc   = (rx_cnt_q == '0);
   assign tx_busy = (tx_state_q != UART_IDLE);
   assign txd     = txd_q;
   assign rx_data = rx_data_q;

   always_comb begin
      tx_state_d    = tx_state_q;
      tx_cnt_d      = tx_cnt_q;
      tx_bit_d      = tx_bit_q;
      tx_shift_d    = tx_shift_q;
      txd_d         = txd_q;
      tx_done_pulse = 1'b0;
      if (tx_state_q != UART_IDLE && !tx_tc) tx_cnt_d = tx_cnt_q - 1'b1;
      case (tx_state_q)
         UART_IDLE: begin
            if (tx_start) begin
               tx_state_d = UART_START;
               tx_cnt_d   = BIT_LAST;
               tx_shift_d = tx_data;
               txd_d      = 1'b0;
            end
         end
         UART_START: begin
            if (tx_tc) begin
               tx_state_d = UART_DATA;
               tx_cnt_d   = BIT_LAST;
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
         end
         UART_DATA: begin
            if (tx_tc) begin
               tx_cnt_d = BIT_LAST;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = UART_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
         end
         UART_STOP: begin
            if (tx_tc) begin
               tx_state_d    = UART_IDLE;
               tx_done_pulse = 1'b1;
            end
         end
         default: tx_state_d = UART_IDLE;
      endcase
   end

   // Start detection uses the synchronized line; the half-bit wait lands the
   // re-check, and every later sample, near the middle of a bit cell.
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_data_d     = rx_data_q;
      rx_done_pulse = 1'b0;
      if (rx_state_q != UART_IDLE && !rx_tc) rx_cnt_d = rx_cnt_q - 1'b1;
      case (rx_state_q)
         UART_IDLE: begin
            if (rxd_prev_q && !rxd_s2_q) begin
               rx_state_d = UART_START;
               rx_cnt_d   = HALF_LAST;
            end
         end
         UART_START: begin
            if (rx_tc) begin
               if (!rxd_s2_q) begin
                  rx_state_d = UART_DATA;
                  rx_cnt_d   = BIT_LAST;
                  rx_bit_d   = 3'd0;
               end else begin
                  rx_state_d = UART_IDLE;
               end
            end
         end
         UART_DATA: begin
            if (rx_tc) begin
               rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
               rx_cnt_d   = BIT_LAST;
               if (rx_bit_q == 3'd7) rx_state_d = UART_STOP;
               else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
         end
         UART_STOP: begin
            if (rx_tc) begin
               rx_state_d = UART_IDLE;
               if (rxd_s2_q) begin
                  rx_data_d     = rx_shift_q;
                  rx_done_pulse = 1'b1;
               end
            end
         end
         default: rx_state_d = UART_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= UART_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         txd_q      <= 1'b1;
         rx_state_q <= UART_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_data_q  <= 8'h00;
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rxd_s1_q   <= rxd;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
      end
   end

endmodule

// File: rtl/peripheral.sv
// Memory-mapped I/O block: reload timer, LED/7-segment outputs, switch input
// and UART, with combinational read-back and a combined interrupt line.
module peripheral
   import peripheral_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
   parameter int BAUD     = BAUD_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [7:0]  switch,
   output logic [31:0] rdata,
   output logic [7:0]  led,
   output logic [11:0] digi,
   output logic        irqout,
   input  logic        PC_Uart_rxd,
   output logic        PC_Uart_txd
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUD;

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [7:0]  led_q, led_d;
   logic [11:0] digi_q, digi_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic [1:0]  con_en_q, con_en_d;
   logic        tx_done_q, tx_done_d;
   logic        rx_done_q, rx_done_d;

   logic        tx_start, tx_busy, tx_done_pulse, rx_done_pulse;
   logic [7:0]  rx_data;

   assign tx_start = wr && (addr == ADDR_UART_TXD) && !tx_busy;
   assign led      = led_q;
   assign digi     = digi_q;
   assign irqout   = tcon_q[2] | (con_en_q[0] & tx_done_q) | (con_en_q[1] & rx_done_q);

   peripheral_uart_core #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_uart_core (
      .clk           (clk),
      .reset         (reset),
      .tx_start      (tx_start),
      .tx_data       (wdata[7:0]),
      .tx_busy       (tx_busy),
      .tx_done_pulse (tx_done_pulse),
      .txd           (PC_Uart_txd),
      .rxd           (PC_Uart_rxd),
      .rx_data       (rx_data),
      .rx_done_pulse (rx_done_pulse)
   );

   // Timer update first so that a CPU write to TL/TCON below overrides it.
   always_comb begin
      th_d      = th_q;
      tl_d      = tl_q;
      tcon_d    = tcon_q;
      led_d     = led_q;
      digi_d    = digi_q;
      tx_data_d = tx_data_q;
      con_en_d  = con_en_q;
      tx_done_d = tx_done_q;
      rx_done_d = rx_done_q;
      if (tcon_q[0]) begin
         if (tl_q == 32'hFFFF_FFFF) begin
            tl_d = th_q;
            if (tcon_q[1]) tcon_d[2] = 1'b1;
         end else begin
            tl_d = tl_q + 32'd1;
         end
      end
      if (wr) begin
         case (addr)
            ADDR_TH:       th_d     = wdata;
            ADDR_TL:       tl_d     = wdata;
            ADDR_TCON:     tcon_d   = wdata[2:0];
            ADDR_LED:      led_d    = wdata[7:0];
            ADDR_DIGI:     digi_d   = wdata[11:0];
            ADDR_UART_CON: con_en_d = wdata[1:0];
            ADDR_UART_TXD: if (!tx_busy) tx_data_d = wdata[7:0];
            default: ;
         endcase
      end
      // A completion arriving in the same cycle as a status read is kept.
      if (rd && addr == ADDR_UART_CON) begin
         tx_done_d = 1'b0;
         rx_done_d = 1'b0;
      end
      if (tx_done_pulse) tx_done_d = 1'b1;
      if (rx_done_pulse) rx_done_d = 1'b1;
   end

   always_comb begin
      rdata = 32'h0;
      if (rd) begin
         case (addr)
            ADDR_TH:       rdata = th_q;
            ADDR_TL:       rdata = tl_q;
            ADDR_TCON:     rdata = {29'h0, tcon_q};
            ADDR_LED:      rdata = {24'h0, led_q};
            ADDR_SWITCH:   rdata = {24'h0, switch};
            ADDR_DIGI:     rdata = {20'h0, digi_q};
            ADDR_UART_TXD: rdata = {24'h0, tx_data_q};
            ADDR_UART_RXD: rdata = {24'h0, rx_data};
            ADDR_UART_CON: rdata = {27'h0, tx_busy, rx_done_q, tx_done_q, con_en_q};
            default:       rdata = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th_q      <= 32'h0;
         tl_q      <= 32'h0;
         tcon_q    <= 3'h0;
         led_q     <= 8'h0;
         digi_q    <= 12'h0;
         tx_data_q <= 8'h0;
         con_en_q  <= 2'h0;
         tx_done_q <= 1'b0;
         rx_done_q <= 1'b0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         led_q     <= led_d;
         digi_q    <= digi_d;
         tx_data_q <= tx_data_d;
         con_en_q  <= con_en_d;
         tx_done_q <= tx_done_d;
         rx_done_q <= rx_done_d;
      end
   end

endmodule

// File: tb/tb_peripheral.sv
// Directed bench for the peripheral; the UART runs at 16 clocks per bit so
// complete frames fit in a short simulation.
module tb_peripheral;
   import peripheral_pkg::*;

   localparam int CLK_F  = 1_600_000;
   localparam int BAUD_R = 100_000;
   localparam int BC     = CLK_F / BAUD_R;

   logic        clk = 1'b0;
   logic        reset, rd, wr;
   logic [31:0] addr, wdata, rdata;
   logic [7:0]  switch, led;
   logic [11:0] digi;
   logic        irqout, rxd, txd;

   int checks = 0;
   int fails  = 0;

   peripheral #(.CLK_FREQ(CLK_F), .BAUD(BAUD_R)) dut (
      .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .switch(switch), .rdata(rdata), .led(led), .digi(digi), .irqout(irqout),
      .PC_Uart_rxd(rxd), .PC_Uart_txd(txd)
   );

   always #10 clk = ~clk;

   task bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); wr = 1'b1; addr = a; wdata = d;
      @(negedge clk); wr = 1'b0;
   endtask

   task bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk); rd = 1'b1; addr = a; #1 d = rdata;
      @(negedge clk); rd = 1'b0;
   endtask

   task send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         rxd = f[k];
         repeat (BC) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task test_reset;
      reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0;
      switch = 8'h00; rxd = 1'b1;
      #12 reset = 1'b0;
      @(negedge clk); #1;
      checks++; if (txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", txd); end
      checks++; if (led !== 8'h00) begin fails++; $display("FAIL reset_led: got %h expected 00", led); end
      checks++; if (digi !== 12'h000) begin fails++; $display("FAIL reset_digi: got %h expected 000", digi); end
      checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irqout); end
      checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      rd = 1'b1; addr = ADDR_UART_CON; #1;
      checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_con: got %h expected 0", rdata); end
      rd = 1'b0;
   endtask

   task test_leds;
      logic [31:0] d;
      switch = 8'h3C;
      bus_write(ADDR_LED, 32'hFFFF_FFA5);
      bus_write(ADDR_DIGI, 32'hFFFF_FABC);
      bus_write(32'h4000_0024, 32'h1234_5678);
      checks++; if (led !== 8'hA5) begin fails++; $display("FAIL led_out: got %h expected a5", led); end
      checks++; if (digi !== 12'hABC) begin fails++; $display("FAIL digi_out: got %h expected abc", digi); end
      bus_read(ADDR_LED, d);
      checks++; if (d !== 32'hA5) begin fails++; $display("FAIL led_read: got %h expected a5", d); end
      bus_read(ADDR_DIGI, d);
      checks++; if (d !== 32'hABC) begin fails++; $display("FAIL digi_read: got %h expected abc", d); end
      bus_read(ADDR_SWITCH, d);
      checks++; if (d !== 32'h3C) begin fails++; $display("FAIL switch_read: got %h expected 3c", d); end
      bus_read(32'h4000_0024, d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h expected 0", d); end
      @(negedge clk); rd = 1'b0; addr = ADDR_LED; #1;
      checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL rd_low: got %h expected 0", rdata); end
   endtask

   task test_timer;
      logic [31:0] d;
      bus_write(ADDR_TH, 32'hFFFF_FFFE);
      bus_write(ADDR_TL, 32'hFFFF_FFFE);
      bus_write(ADDR_TCON, 32'h3);
      rd = 1'b1; addr = ADDR_TL; #1;
      checks++; if (rdata !== 32'hFFFF_FFFE) begin fails++; $display("FAIL timer_start: got %h expected fffffffe", rdata); end
      @(negedge clk); #1;
      checks++; if (rdata !== 32'hFFFF_FFFF) begin fails++; $display("FAIL timer_inc: got %h expected ffffffff", rdata); end
      checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL timer_irq_early: got %b expected 0", irqout); end
      @(negedge clk); #1;
      checks++; if (rdata !== 32'hFFFF_FFFE) begin fails++; $display("FAIL timer_reload: got %h expected fffffffe", rdata); end
      checks++; if (irqout !== 1'b1) begin fails++; $display("FAIL timer_irq: got %b expected 1", irqout); end
      addr = ADDR_TCON; #1;
      checks++; if (rdata !== 32'h7) begin fails++; $display("FAIL timer_tcon: got %h expected 7", rdata); end
      rd = 1'b0;
      bus_write(ADDR_TCON, 32'h0);
      checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL timer_irq_clear: got %b expected 0", irqout); end
      // Wrap with interrupts disabled: reloads but leaves the status bit clear.
      bus_write(ADDR_TH, 32'h1234_5678);
      bus_write(ADDR_TL, 32'hFFFF_FFFF);
      bus_write(ADDR_TCON, 32'h1);
      bus_write(ADDR_TCON, 32'h0);
      bus_read(ADDR_TL, d);
      checks++; if (d !== 32'h1234_5679) begin fails++; $display("FAIL timer_noirq_tl: got %h expected 12345679", d); end
      bus_read(ADDR_TCON, d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL timer_noirq_tcon: got %h expected 0", d); end
   endtask

   task test_uart_tx;
      logic [9:0]  frame;
      logic [31:0] d;
      int bad;
      frame = {1'b1, 8'h2D, 1'b0};
      bus_write(ADDR_UART_TXD, 32'h2D);
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int c = 0; c < BC; c++) begin
            if (k == 5 && c == 0) begin
               rd = 1'b1; addr = ADDR_UART_CON; #1;
               checks++; if (rdata !== 32'h10) begin fails++; $display("FAIL tx_busy: got %h expected 10", rdata); end
            end else begin
               rd = 1'b0;
            end
            if (txd !== frame[k]) bad++;
            @(negedge clk);
         end
         checks++; if (bad != 0) begin fails++; $display("FAIL tx_bit%0d: %0d cycles wrong, expected level %b", k, bad, frame[k]); end
      end
      rd = 1'b0;
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h4) begin fails++; $display("FAIL tx_done: got %h expected 4", d); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL tx_done_clear: got %h expected 0", d); end
   endtask

   task test_tx_busy_ignore;
      logic [31:0] d;
      bus_write(ADDR_UART_CON, 32'h1);
      bus_write(ADDR_UART_TXD, 32'h55);
      bus_write(ADDR_UART_TXD, 32'hAA);
      bus_read(ADDR_UART_TXD, d);
      checks++; if (d !== 32'h55) begin fails++; $display("FAIL tx_ignore: got %h expected 55", d); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h11) begin fails++; $display("FAIL tx_busy_con: got %h expected 11", d); end
      repeat (10 * BC) @(negedge clk);
      checks++; if (irqout !== 1'b1) begin fails++; $display("FAIL tx_irq: got %b expected 1", irqout); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h5) begin fails++; $display("FAIL tx_irq_con: got %h expected 5", d); end
      checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL tx_irq_clear: got %b expected 0", irqout); end
      bus_write(ADDR_UART_CON, 32'h0);
   endtask

   task test_uart_rx;
      logic [31:0] d;
      send_rx(8'h23, 1'b1);
      bus_read(ADDR_UART_RXD, d);
      checks++; if (d !== 32'h23) begin fails++; $display("FAIL rx_23: got %h expected 23", d); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h8) begin fails++; $display("FAIL rx_done: got %h expected 8", d); end
      send_rx(8'h41, 1'b1);
      bus_read(ADDR_UART_RXD, d);
      checks++; if (d !== 32'h41) begin fails++; $display("FAIL rx_41: got %h expected 41", d); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h8) begin fails++; $display("FAIL rx_done2: got %h expected 8", d); end
   endtask

   task test_rx_irq;
      logic [31:0] d;
      bus_write(ADDR_UART_CON, 32'h2);
      send_rx(8'h5A, 1'b1);
      checks++; if (irqout !== 1'b1) begin fails++; $display("FAIL rx_irq: got %b expected 1", irqout); end
      bus_read(ADDR_UART_RXD, d);
      checks++; if (d !== 32'h5A) begin fails++; $display("FAIL rx_5a: got %h expected 5a", d); end
      checks++; if (irqout !== 1'b1) begin fails++; $display("FAIL rx_irq_hold: got %b expected 1", irqout); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'hA) begin fails++; $display("FAIL rx_irq_con: got %h expected a", d); end
      checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL rx_irq_clear: got %b expected 0", irqout); end
      bus_write(ADDR_UART_CON, 32'h0);
   endtask

   task test_rx_framing;
      logic [31:0] d;
      send_rx(8'hC3, 1'b0);
      bus_read(ADDR_UART_RXD, d);
      checks++; if (d !== 32'h5A) begin fails++; $display("FAIL rx_frame_data: got %h expected 5a", d); end
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL rx_frame_done: got %h expected 0", d); end
   endtask

   task test_reset_mid_frame;
      logic [31:0] d;
      bus_write(ADDR_UART_TXD, 32'h00);
      repeat (BC + 4) @(negedge clk);
      checks++; if (txd !== 1'b0) begin fails++; $display("FAIL midreset_active: got %b expected 0", txd); end
      reset = 1'b1; #1;
      checks++; if (txd !== 1'b1) begin fails++; $display("FAIL midreset_txd: got %b expected 1", txd); end
      checks++; if (led !== 8'h00) begin fails++; $display("FAIL midreset_led: got %h expected 00", led); end
      @(negedge clk); reset = 1'b0;
      bus_read(ADDR_UART_CON, d);
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL midreset_con: got %h expected 0", d); end
      checks++; if (txd !== 1'b1) begin fails++; $display("FAIL midreset_idle: got %b expected 1", txd); end
   endtask

   initial begin
      test_reset;
      test_leds;
      test_timer;
      test_uart_tx;
      test_tx_busy_ignore;
      test_uart_rx;
      test_rx_irq;
      test_rx_framing;
      test_reset_mid_frame;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/peripheral.md
Name: peripheral

Overview:
Memory-mapped I/O block on the CPU data bus at base 0x40000000. It provides:
- a reload timer with interrupt,
- LED and 7-segment output registers,
- a switch input,
- a 9600-baud 8N1 UART (TX and RX) with status and interrupt.

It sits beside data memory. The CPU selects it by address and reads it combinationally.

Parameters:
CLK_FREQ, 50_000_000, clk frequency in Hz
BAUD, 9600, UART bit rate; BIT_CYCLES = CLK_FREQ/BAUD = 5208

Ports:
clk  in  1  sole clock, 50 MHz; all registers on posedge
reset  in  1  asynchronous, active-high; clears all state
rd  in  1  read enable
wr  in  1  write enable, sampled on posedge clk
addr  in  32  byte address
wdata  in  32  write data
switch  in  8  board switches
rdata  out  32  read data
led  out  8  LED register
digi  out  12  7-segment drive register
irqout  out  1  interrupt request to CPU
PC_Uart_rxd  in  1  UART receive line, idle high
PC_Uart_txd  out  1  UART transmit line, idle high

Behaviour:
- Register map; writes take effect on posedge clk when wr=1; other addresses ignored:
  - 0x40000000 TH: 32b timer reload, R/W.
  - 0x40000004 TL: 32b timer count, R/W.
  - 0x40000008 TCON: [0] enable, [1] irq enable, [2] irq status; R/W 3b, upper bits read 0.
  - 0x4000000C LED: R/W wdata[7:0] -> led.
  - 0x40000010 SWITCH: read-only {24'b0, switch}.
  - 0x40000014 DIGI: R/W wdata[11:0] -> digi.
  - 0x40000018 UART_TXD: write wdata[7:0] loads TX data and starts a frame if TX idle; the write is ignored while busy; reads last TX byte.
  - 0x4000001C UART_RXD: read-only, last received byte.
  - 0x40000020 UART_CON: [0] TX irq enable (R/W), [1] RX irq enable (R/W), [2] TX done (RO), [3] RX done (RO), [4] TX busy (RO).
- Reads:
  - rdata is combinational: register value when rd=1 and addr is mapped; otherwise 32'h0.
  - A read of UART_CON clears bits [2] and [3] on the next posedge clk (rd=1 with that address in that cycle).
  - Reading UART_RXD does not clear status.
- Timer, when TCON[0]=1, each cycle:
  - If TL==32'hFFFFFFFF: TL<=TH, and TCON[2]<=1 if TCON[1].
  - Otherwise TL<=TL+1.
  - A CPU write to TL/TCON in the same cycle wins.
- irqout = TCON[2] | (CON[0]&CON[2]) | (CON[1]&CON[3]), combinational.
- UART TX, states IDLE -> START -> DATA(8, LSB first) -> STOP -> IDLE:
  - Each bit is held BIT_CYCLES clocks.
  - txd goes low on the cycle after the accepted write.
  - busy is 1 from accept until the stop bit ends.
  - At stop end: CON[2]<=1, busy<=0.
  - Total frame = 10*BIT_CYCLES cycles.
- UART RX, states IDLE -> START -> DATA -> STOP -> IDLE:
  - rxd is passed through a 2-flop synchronizer.
  - A falling edge in IDLE starts a frame; the start bit is re-checked at BIT_CYCLES/2 and a false start returns to IDLE.
  - Data bits are sampled every BIT_CYCLES after the mid-start sample, LSB first.
  - At the stop-bit sample, if high: RXD<=byte, CON[3]<=1.
  - If the stop bit is low (framing error), the byte is discarded and the block returns to IDLE.
  - A new byte overwrites RXD even if not yet read.
- Reset values: TH=TL=TCON=0, led=0, digi=0, TX/RX data=0, CON=0, txd=1, rdata follows rd/addr, irqout=0.
- Reset mid-frame aborts the frame immediately and returns txd to 1.

Decomposition:
- Shared package: register address constants (TH..UART_CON), CLK_FREQ/BAUD defaults, UART state enum.
- One natural sub-module, uart_core: TX and RX shifters with baud counters. It exposes tx_start/tx_data/tx_busy/tx_done_pulse and rx_data/rx_done_pulse.
- Bus decode, timer and status bits stay in peripheral.

Test Plan:
- Reset asserted 10 ns then released -> txd=1, led=0, digi=0, irqout=0, rdata=0 with rd=0.
- Write 0x2D to 0x40000018 for one cycle -> txd waveform 0,1,0,1,1,0,1,0,0,1, each 104.16 µs. UART_CON[4]=1 during the frame; [2]=1 after it.
- Drive rxd 8N1 byte 0x23 (bit cells 0,1,1,0,0,0,1,0,0,1 at 104167 ns), then read 0x4000001C -> rdata=32'h23, UART_CON[3]=1. Repeat with 0x41 -> rdata=32'h41.
- CON=0x2 and RX byte received -> irqout=1; read 0x40000020 -> [3] clears, irqout=0.
- TH=0xFFFFFFFE, TL=0xFFFFFFFE, TCON=3 -> TL=FFFFFFFF, then reloads to FFFFFFFE with TCON[2]=1 and irqout=1.
- Write LED=0xA5 and DIGI=0xABC, switch=0x3C -> led=A5, digi=ABC; reads return 0xA5, 0xABC, 0x3C; unmapped address read -> 0.
